// File: rtl/flash_nt_pkg.sv
// Shared types and constants for the flash-to-nametable loader.
package flash_nt_pkg;

    localparam logic [7:0] FLASH_CMD_READ = 8'h03;
    localparam int unsigned HDR_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SEND,
        ST_WAIT_LO,
        ST_WAIT_HI,
        ST_HOLD,
        ST_FIN
    } state_t;

    // Command/address header byte for header position idx.
    function automatic logic [7:0] hdr_byte(input logic [1:0] idx, input logic [23:0] addr);
        logic [7:0] b;
        case (idx)
            2'd0:    b = FLASH_CMD_READ;
            2'd1:    b = addr[23:16];
            2'd2:    b = addr[15:8];
            default: b = addr[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/cyc_counter.sv
// Loadable saturating down-counter with a zero flag.
module cyc_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero_c
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/flash_nametable_loader.sv
// Issues an SPI-flash READ and streams the returned bytes into nametable RAM.
module flash_nametable_loader
    import flash_nt_pkg::*;
#(
    parameter int unsigned NT_AW    = 10,
    parameter int unsigned CLK_DIV  = 8,
    parameter int unsigned CS_SETUP = 4,
    parameter int unsigned CS_HOLD  = 4,
    parameter int unsigned TIMEOUT  = 4096
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [23:0]      flash_addr,
    input  logic [NT_AW:0]   len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [7:0]       spi_clk_div,
    output logic             cs,
    output logic             tx_req,
    output logic [7:0]       data_tx,
    input  logic [7:0]       data_rx,
    input  logic             spi_ready,
    output logic             nt_we,
    output logic [NT_AW-1:0] nt_addr,
    output logic [7:0]       nt_wdata
);

    localparam int unsigned KW       = NT_AW + 2;
    localparam int unsigned SW       = 8;
    localparam int unsigned TW       = $clog2(TIMEOUT + 1);
    localparam int unsigned SETUP_LD = (CS_SETUP > 0) ? CS_SETUP - 1 : 0;
    localparam int unsigned HOLD_LD  = (CS_HOLD > 0) ? CS_HOLD - 1 : 0;
    localparam int unsigned TO_LD    = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    state_t            state, state_d;
    logic [KW-1:0]     k, k_d, k_inc;
    logic [23:0]       addr_q, addr_d;
    logic [NT_AW:0]    len_q, len_d;
    logic              busy_d, done_d, err_d, cs_d, tx_req_d, nt_we_d;
    logic [7:0]        data_tx_d, nt_wdata_d;
    logic [NT_AW-1:0]  nt_addr_d;
    logic              tmr_load, tmr_en, tmr_zero;
    logic [SW-1:0]     tmr_val;
    logic              to_load, to_en, to_zero;

    assign spi_clk_div = 8'(CLK_DIV);

    function automatic logic [7:0] byte_for(input logic [KW-1:0] kv, input logic [23:0] a);
        if (kv < KW'(HDR_BYTES)) begin
            return hdr_byte(kv[1:0], a);
        end
        return 8'h00;
    endfunction

    cyc_counter #(.W(SW)) u_frame_tmr (
        .clk      (clk),
        .rstn     (rstn),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (tmr_val),
        .zero_c   (tmr_zero)
    );

    cyc_counter #(.W(TW)) u_byte_timeout (
        .clk      (clk),
        .rstn     (rstn),
        .load     (to_load),
        .en       (to_en),
        .load_val (TW'(TO_LD)),
        .zero_c   (to_zero)
    );

    // Next state and next values of every registered output.
    always_comb begin
        state_d    = state;
        k_d        = k;
        addr_d     = addr_q;
        len_d      = len_q;
        busy_d     = busy;
        done_d     = 1'b0;
        err_d      = err;
        cs_d       = cs;
        tx_req_d   = 1'b0;
        data_tx_d  = data_tx;
        nt_we_d    = 1'b0;
        nt_addr_d  = nt_addr;
        nt_wdata_d = nt_wdata;
        tmr_load   = 1'b0;
        tmr_en     = 1'b0;
        tmr_val    = '0;
        to_load    = 1'b0;
        to_en      = 1'b0;
        k_inc      = k + KW'(1);

        case (state)
            ST_IDLE: begin
                if (start) begin
                    addr_d = flash_addr;
                    len_d  = len;
                    err_d  = 1'b0;
                    busy_d = 1'b1;
                    k_d    = '0;
                    if (len == '0) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d  = ST_SETUP;
                        cs_d     = 1'b0;
                        tmr_load = 1'b1;
                        tmr_val  = SW'(SETUP_LD);
                    end
                end
            end
            ST_SETUP: begin
                tmr_en = 1'b1;
                if (tmr_zero && spi_ready) begin
                    state_d   = ST_SEND;
                    tx_req_d  = 1'b1;
                    data_tx_d = byte_for(k, addr_q);
                end
            end
            ST_SEND: begin
                to_load = 1'b1;
                state_d = ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
                to_en = 1'b1;
                if (!spi_ready) begin
                    state_d = ST_WAIT_HI;
                end else if (to_zero) begin
                    err_d   = 1'b1;
                    cs_d    = 1'b1;
                    state_d = ST_FIN;
                end
            end
            ST_WAIT_HI: begin
                to_en = 1'b1;
                if (spi_ready) begin
                    // Header bytes are clocked but never written.
                    if (k >= KW'(HDR_BYTES)) begin
                        nt_we_d    = 1'b1;
                        nt_addr_d  = NT_AW'(k - KW'(HDR_BYTES));
                        nt_wdata_d = data_rx;
                    end
                    k_d = k_inc;
                    if (k_inc == KW'(len_q) + KW'(HDR_BYTES)) begin
                        state_d  = ST_HOLD;
                        tmr_load = 1'b1;
                        tmr_val  = SW'(HOLD_LD);
                    end else begin
                        state_d   = ST_SEND;
                        tx_req_d  = 1'b1;
                        data_tx_d = byte_for(k_inc, addr_q);
                    end
                end else if (to_zero) begin
                    err_d   = 1'b1;
                    cs_d    = 1'b1;
                    state_d = ST_FIN;
                end
            end
            ST_HOLD: begin
                tmr_en = 1'b1;
                if (tmr_zero) begin
                    cs_d    = 1'b1;
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            k        <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            cs       <= 1'b1;
            tx_req   <= 1'b0;
            data_tx  <= '0;
            nt_we    <= 1'b0;
            nt_addr  <= '0;
            nt_wdata <= '0;
        end else begin
            state    <= state_d;
            k        <= k_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            busy     <= busy_d;
            done     <= done_d;
            err      <= err_d;
            cs       <= cs_d;
            tx_req   <= tx_req_d;
            data_tx  <= data_tx_d;
            nt_we    <= nt_we_d;
            nt_addr  <= nt_addr_d;
            nt_wdata <= nt_wdata_d;
        end
    end

endmodule

// File: tb/tb_flash_nametable_loader.sv
// Scoreboard bench: SPI engine + flash model, queued expectations checked by a monitor.
module tb_flash_nametable_loader;

    localparam int NT_AW    = 10;
    localparam int CS_SETUP = 4;
    localparam int CS_HOLD  = 4;
    localparam int TIMEOUT  = 4096;
    localparam int BYTE_T   = 8;

    typedef struct {
        logic [NT_AW-1:0] a;
        logic [7:0]       d;
    } wr_t;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             start = 1'b0;
    logic [23:0]      flash_addr = '0;
    logic [NT_AW:0]   len = '0;
    logic             busy, done, err, cs, tx_req, nt_we;
    logic [7:0]       spi_clk_div, data_tx, nt_wdata;
    logic [NT_AW-1:0] nt_addr;
    logic [7:0]       data_rx = 8'h00;
    logic             spi_ready = 1'b1;

    logic [7:0] exp_tx[$];
    wr_t        exp_wr[$];
    int         errors = 0;
    int         checks = 0;
    int         done_cnt = 0;
    int         last_wr = -1;

    always #5 clk = ~clk;

    flash_nametable_loader #(
        .NT_AW(NT_AW), .CLK_DIV(8), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .flash_addr(flash_addr), .len(len),
        .busy(busy), .done(done), .err(err), .spi_clk_div(spi_clk_div), .cs(cs),
        .tx_req(tx_req), .data_tx(data_tx), .data_rx(data_rx), .spi_ready(spi_ready),
        .nt_we(nt_we), .nt_addr(nt_addr), .nt_wdata(nt_wdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] flash_f(input logic [23:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    // SPI engine + flash model: ready drops 2 cycles after a request, data after BYTE_T.
    int          eng_cnt = 0;
    int          fpos = 0;
    logic [23:0] faddr = '0;
    logic [7:0]  rx_next = 8'h00;
    logic        hang = 1'b0;
    logic        eng_clear = 1'b0;

    always @(posedge clk) begin
        if (cs) fpos <= 0;
        if (eng_clear) begin
            eng_cnt   <= 0;
            spi_ready <= 1'b1;
        end else if (eng_cnt == 0) begin
            if (tx_req && !cs) begin
                eng_cnt <= 1;
                fpos    <= fpos + 1;
                case (fpos)
                    1: faddr[23:16] <= data_tx;
                    2: faddr[15:8]  <= data_tx;
                    3: faddr[7:0]   <= data_tx;
                    default: ;
                endcase
                rx_next <= (fpos >= 4) ? flash_f(faddr + 24'(fpos - 4)) : 8'hFF;
            end
        end else if (eng_cnt == 1) begin
            spi_ready <= 1'b0;
            eng_cnt   <= 2;
        end else if (!hang) begin
            if (eng_cnt == BYTE_T + 1) begin
                spi_ready <= 1'b1;
                data_rx   <= rx_next;
                eng_cnt   <= 0;
            end else begin
                eng_cnt <= eng_cnt + 1;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a request or write.
    logic [7:0] mon_tx;
    wr_t        mon_wr;
    always @(negedge clk) begin
        if (tx_req) begin
            if (exp_tx.size() == 0) begin
                checks++; errors++;
                $display("FAIL tx_unexpected: got 0x%0h expected none", data_tx);
            end else begin
                mon_tx = exp_tx.pop_front();
                check("tx_byte", 32'(data_tx), 32'(mon_tx));
            end
        end
        if (nt_we) begin
            last_wr = int'(nt_addr);
            if (exp_wr.size() == 0) begin
                checks++; errors++;
                $display("FAIL wr_unexpected: got addr %0d data 0x%0h expected none", nt_addr, nt_wdata);
            end else begin
                mon_wr = exp_wr.pop_front();
                check("nt_write", 32'({nt_addr, nt_wdata}), 32'({mon_wr.a, mon_wr.d}));
            end
        end
        if (done) begin
            done_cnt++;
            check("busy_low_at_done", 32'(busy), 32'(0));
        end
    end

    task automatic push_tx_frame(input logic [23:0] a, input int n);
        exp_tx.push_back(8'h03);
        exp_tx.push_back(a[23:16]);
        exp_tx.push_back(a[15:8]);
        exp_tx.push_back(a[7:0]);
        for (int i = 0; i < n; i++) exp_tx.push_back(8'h00);
    endtask

    task automatic push_wr(input int a, input logic [7:0] d);
        wr_t w;
        w.a = NT_AW'(a);
        w.d = d;
        exp_wr.push_back(w);
    endtask

    task automatic do_start(input logic [23:0] a, input logic [NT_AW:0] n);
        @(negedge clk);
        start = 1'b1; flash_addr = a; len = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done_seen"}, 32'(done), 32'(1));
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        check({name, "_cs_high"}, 32'(cs), 32'(1));
        check({name, "_busy_low"}, 32'(busy), 32'(0));
        check({name, "_tx_left"}, 32'(exp_tx.size()), 32'(0));
        check({name, "_wr_left"}, 32'(exp_wr.size()), 32'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt;
        int d0;

        repeat (3) @(negedge clk);
        check("rst_cs", 32'(cs), 32'(1));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_err", 32'(err), 32'(0));
        check("rst_tx_req", 32'(tx_req), 32'(0));
        check("rst_nt_we", 32'(nt_we), 32'(0));
        check("rst_outs", 32'({data_tx, nt_wdata}), 32'(0));
        check("rst_nt_addr", 32'(nt_addr), 32'(0));
        check("clk_div", 32'(spi_clk_div), 32'(8));
        rstn = 1'b1;

        // Nominal 4-byte load: data = low address byte ^ 0xA5.
        push_tx_frame(24'h012345, 4);
        push_wr(0, 8'hE0); push_wr(1, 8'hE3); push_wr(2, 8'hE2); push_wr(3, 8'hED);
        d0 = done_cnt;
        do_start(24'h012345, 11'd4);
        check("nom_cs_fall", 32'(cs), 32'(0));
        check("nom_busy_set", 32'(busy), 32'(1));
        n = 0;
        while (tx_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("nom_setup_cycles", 32'(n), 32'(CS_SETUP));
        wait_done(2000, "nom");
        check_idle("nom");
        check("nom_done_width", 32'(done), 32'(0));
        check("nom_done_cnt", 32'(done_cnt - d0), 32'(1));

        // len = 0: done two cycles after start, cs never falls.
        do_start(24'h777777, '0);
        check("len0_busy", 32'(busy), 32'(1));
        check("len0_no_early_done", 32'(done), 32'(0));
        check("len0_cs_c1", 32'(cs), 32'(1));
        @(negedge clk);
        check("len0_done", 32'(done), 32'(1));
        check("len0_cs_c2", 32'(cs), 32'(1));
        @(negedge clk);
        check("len0_done_clear", 32'(done), 32'(0));

        // Hung engine: ready never returns after the first request.
        hang = 1'b1;
        exp_tx.push_back(8'h03);
        do_start(24'h000010, 11'd2);
        n = 1;
        while (err !== 1'b1 && n < TIMEOUT + 100) begin
            @(negedge clk);
            n++;
        end
        check("to_err", 32'(err), 32'(1));
        check("to_cs", 32'(cs), 32'(1));
        check("to_window", 32'(n >= TIMEOUT && n <= TIMEOUT + 20), 32'(1));
        wait_done(4, "to");
        @(negedge clk);
        check("to_err_sticky", 32'(err), 32'(1));
        hang = 1'b0;
        eng_clear = 1'b1;
        @(negedge clk);
        eng_clear = 1'b0;
        push_tx_frame(24'h000020, 1);
        push_wr(0, 8'h85);
        do_start(24'h000020, 11'd1);
        check("to_err_cleared", 32'(err), 32'(0));
        wait_done(500, "to_rec");
        check_idle("to_rec");

        // start while busy is ignored.
        push_tx_frame(24'h0000A0, 3);
        push_wr(0, 8'h05); push_wr(1, 8'h04); push_wr(2, 8'h07);
        do_start(24'h0000A0, 11'd3);
        repeat (20) @(negedge clk);
        start = 1'b1; flash_addr = 24'hFFFFFF; len = 11'd5;
        @(negedge clk);
        start = 1'b0;
        check("busy_start_ignored", 32'(busy), 32'(1));
        check("busy_start_cs", 32'(cs), 32'(0));
        wait_done(1000, "ign");
        check_idle("ign");

        // Reset during the sixth byte; only the first data write may happen.
        push_tx_frame(24'h000100, 2);
        push_wr(0, 8'hA5);
        do_start(24'h000100, 11'd4);
        n = 0; cnt = 0;
        while (cnt < 6 && n < 500) begin
            @(negedge clk);
            n++;
            if (tx_req) cnt++;
        end
        check("rst_reached_byte6", 32'(cnt), 32'(6));
        #1 rstn = 1'b0;
        @(negedge clk);
        check("midrst_cs", 32'(cs), 32'(1));
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_nt_we", 32'(nt_we), 32'(0));
        check("midrst_tx_req", 32'(tx_req), 32'(0));
        rstn = 1'b1;
        n = 0;
        while ((spi_ready !== 1'b1 || eng_cnt != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("midrst_engine_idle", 32'(spi_ready), 32'(1));
        check("midrst_tx_left", 32'(exp_tx.size()), 32'(0));
        check("midrst_wr_left", 32'(exp_wr.size()), 32'(0));
        push_tx_frame(24'h000100, 8);
        push_wr(0, 8'hA5); push_wr(1, 8'hA4); push_wr(2, 8'hA7); push_wr(3, 8'hA6);
        push_wr(4, 8'hA1); push_wr(5, 8'hA0); push_wr(6, 8'hA3); push_wr(7, 8'hA2);
        do_start(24'h000100, 11'd8);
        wait_done(2000, "post_rst");
        check_idle("post_rst");

        // Full table: 1024 writes ending at 1023, no wrap.
        push_tx_frame(24'h000000, 1024);
        for (int i = 0; i < 1024; i++) push_wr(i, 8'(i) ^ 8'hA5);
        d0 = done_cnt;
        do_start(24'h000000, 11'd1024);
        wait_done(40000, "full");
        check_idle("full");
        check("full_last_addr", 32'(last_wr), 32'(1023));
        check("full_done_cnt", 32'(done_cnt - d0), 32'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
